vga_timing_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 VGA controller.
- Generates H/V sync, blank and pixel-request timing for any mode set by parameters, with configurable sync polarity and colour width.
- Requests pixels from a host renderer with a fixed, parameterised read latency. Delays sync and blank internally so RGB, sync and blank reach the DAC aligned.
- Forces RGB to zero outside the active window. The DE2-70 DAC blanks the whole picture if RGB is non-zero during sync or porch intervals.

---
 rtl/vga_timing_gen.sv | 183 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: 12-bit H/V counters, one-clock request stage, PIX_LAT-deep host wait.
// Define VGA_TESTPATTERN_EN to add iTP_En, which swaps host colour for 8 colour bars with a white border.
module vga_timing_gen #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_ACT   = 640,
  parameter int H_FRONT = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_ACT   = 480,
  parameter int V_FRONT = 10,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0,
  parameter int COLOR_W = 10,
  parameter int PIX_LAT = 1
) (
  input  logic               iCLK,
  input  logic               iRST,
`ifdef VGA_TESTPATTERN_EN
  input  logic               iTP_En,
`endif
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  output logic               oReq,
  output logic [10:0]        oCoord_X,
  output logic [10:0]        oCoord_Y,
  output logic               oFrame_Start,
  output logic               oLine_Start,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               oVGA_H_SYNC,
  output logic               oVGA_V_SYNC,
  output logic               oVGA_BLANK,
  output logic               oVGA_SYNC,
  output logic               oVGA_CLOCK
);
  localparam int H_TOT = H_SYNC + H_BACK + H_ACT + H_FRONT;
  localparam int V_TOT = V_SYNC + V_BACK + V_ACT + V_FRONT;
  localparam int H_A0  = H_SYNC + H_BACK;
  localparam int V_A0  = V_SYNC + V_BACK;

  logic [11:0] h_q, h_d, v_q, v_d;
  logic        hs_act, vs_act, active;
  logic        req_q, fs_q, ls_q;
  logic [10:0] cx_q, cy_q;
  logic [2:0]  dly_q [0:PIX_LAT];
  logic [2:0]  tap;
  logic        hs_o_q, vs_o_q, blank_q;
  logic [COLOR_W-1:0] r_q, g_q, b_q;
  logic [COLOR_W-1:0] src_r, src_g, src_b;

  always_comb begin
    h_d = h_q + 12'd1;
    v_d = v_q;
    if (h_q == 12'(H_TOT - 1)) begin
      h_d = '0;
      v_d = (v_q == 12'(V_TOT - 1)) ? '0 : v_q + 12'd1;
    end
  end

  assign hs_act = h_q < 12'(H_SYNC);
  assign vs_act = v_q < 12'(V_SYNC);
  assign active = (h_q >= 12'(H_A0)) && (h_q < 12'(H_A0 + H_ACT)) &&
                  (v_q >= 12'(V_A0)) && (v_q < 12'(V_A0 + V_ACT));

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      h_q   <= '0;
      v_q   <= '0;
      req_q <= 1'b0;
      fs_q  <= 1'b0;
      ls_q  <= 1'b0;
      cx_q  <= '0;
      cy_q  <= '0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      req_q <= active;
      fs_q  <= (h_q == 12'd0) && (v_q == 12'd0);
      ls_q  <= active && (h_q == 12'(H_A0));
      if (active) begin
        cx_q <= 11'(h_q - 12'(H_A0));
        cy_q <= 11'(v_q - 12'(V_A0));
      end
    end
  end

  // {hs, vs, active}: entry 0 is aligned with oReq, the tap with host colour arrival
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int i = 0; i <= PIX_LAT; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= {hs_act, vs_act, active};
      for (int i = 1; i <= PIX_LAT; i++) dly_q[i] <= dly_q[i-1];
    end
  end
  assign tap = dly_q[PIX_LAT];

`ifdef VGA_TESTPATTERN_EN
  logic                 tp_en_q;
  logic [2:0]           bar;
  logic [3*COLOR_W:0]   tp_cur, tp_tap;
  logic [COLOR_W-1:0]   tp_r, tp_g, tp_b;

  always_ff @(posedge iCLK) begin
    if (iRST) tp_en_q <= 1'b0;
    else      tp_en_q <= iTP_En;
  end

  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++)
      if (cx_q >= 11'(k * H_ACT / 8)) bar = 3'(k);
    tp_r = bar[2] ? '1 : '0;
    tp_g = bar[1] ? '1 : '0;
    tp_b = bar[0] ? '1 : '0;
    if (cx_q == 11'd0 || cx_q == 11'(H_ACT - 1) || cy_q == 11'd0 || cy_q == 11'(V_ACT - 1)) begin
      tp_r = '1;
      tp_g = '1;
      tp_b = '1;
    end
    tp_cur = {tp_en_q, tp_r, tp_g, tp_b};
  end

  if (PIX_LAT == 0) begin : g_tp_nodly
    assign tp_tap = tp_cur;
  end else begin : g_tp_dly
    logic [3*COLOR_W:0] tp_dly_q [0:PIX_LAT-1];
    always_ff @(posedge iCLK) begin
      if (iRST) begin
        for (int i = 0; i < PIX_LAT; i++) tp_dly_q[i] <= '0;
      end else begin
        tp_dly_q[0] <= tp_cur;
        for (int i = 1; i < PIX_LAT; i++) tp_dly_q[i] <= tp_dly_q[i-1];
      end
    end
    assign tp_tap = tp_dly_q[PIX_LAT-1];
  end

  assign src_r = tp_tap[3*COLOR_W] ? tp_tap[3*COLOR_W-1:2*COLOR_W] : iRed;
  assign src_g = tp_tap[3*COLOR_W] ? tp_tap[2*COLOR_W-1:COLOR_W]   : iGreen;
  assign src_b = tp_tap[3*COLOR_W] ? tp_tap[COLOR_W-1:0]           : iBlue;
`else
  assign src_r = iRed;
  assign src_g = iGreen;
  assign src_b = iBlue;
`endif

  // RGB is gated by the delayed active flag so porches and sync stay black at the DAC
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      hs_o_q  <= ~HS_POL;
      vs_o_q  <= ~VS_POL;
      blank_q <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      hs_o_q  <= tap[2] ? HS_POL : ~HS_POL;
      vs_o_q  <= tap[1] ? VS_POL : ~VS_POL;
      blank_q <= tap[0];
      r_q     <= tap[0] ? src_r : '0;
      g_q     <= tap[0] ? src_g : '0;
      b_q     <= tap[0] ? src_b : '0;
    end
  end

  assign oReq         = req_q;
  assign oCoord_X     = cx_q;
  assign oCoord_Y     = cy_q;
  assign oFrame_Start = fs_q;
  assign oLine_Start  = ls_q;
  assign oVGA_R       = r_q;
  assign oVGA_G       = g_q;
  assign oVGA_B       = b_q;
  assign oVGA_H_SYNC  = hs_o_q;
  assign oVGA_V_SYNC  = vs_o_q;
  assign oVGA_BLANK   = blank_q;
  assign oVGA_SYNC    = 1'b0;
  assign oVGA_CLOCK   = iCLK;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: small modes at PIX_LAT 0/1/3, mid-frame reset, 640x480 defaults.
// With VGA_TESTPATTERN_EN defined the default instance runs with the colour-bar pattern enabled.
module tb_vga_timing_gen;
  logic clk, rst, rst_pulse, rst_s;
  int   n_assert, n_fail, cyc;
  logic [7:0] s_red, s_pend, ff8;
  logic [9:0] d_in;
  logic [7:0] exp_q[$];

  logic s_req, s_fs, s_ls, s_hs, s_vs, s_bl, s_sync, s_clk;
  logic [10:0] s_x, s_y;
  logic [7:0] s_r, s_g, s_b;
  logic p0_req, p0_fs, p0_ls, p0_hs, p0_vs, p0_bl, p0_sync, p0_clk;
  logic [10:0] p0_x, p0_y;
  logic [7:0] p0_r, p0_g, p0_b;
  logic p3_req, p3_fs, p3_ls, p3_hs, p3_vs, p3_bl, p3_sync, p3_clk;
  logic [10:0] p3_x, p3_y;
  logic [7:0] p3_r, p3_g, p3_b;
  logic d_req, d_fs, d_ls, d_hs, d_vs, d_bl, d_sync, d_clk;
  logic [10:0] d_x, d_y;
  logic [9:0] d_r, d_g, d_b;
`ifdef VGA_TESTPATTERN_EN
  logic tp_on, tp_off;
  assign tp_on  = 1'b1;
  assign tp_off = 1'b0;
`endif

  assign rst_s = rst | rst_pulse;
  assign ff8   = 8'hFF;
  assign d_in  = 10'h000;

  vga_timing_gen #(.H_SYNC(2), .H_BACK(2), .H_ACT(4), .H_FRONT(2), .V_SYNC(1), .V_BACK(1),
                   .V_ACT(3), .V_FRONT(1), .HS_POL(1'b1), .VS_POL(1'b0), .COLOR_W(8), .PIX_LAT(1)) u_s (
    .iCLK(clk), .iRST(rst_s),
`ifdef VGA_TESTPATTERN_EN
    .iTP_En(tp_off),
`endif
    .iRed(s_red), .iGreen(ff8), .iBlue(ff8), .oReq(s_req), .oCoord_X(s_x), .oCoord_Y(s_y),
    .oFrame_Start(s_fs), .oLine_Start(s_ls), .oVGA_R(s_r), .oVGA_G(s_g), .oVGA_B(s_b),
    .oVGA_H_SYNC(s_hs), .oVGA_V_SYNC(s_vs), .oVGA_BLANK(s_bl), .oVGA_SYNC(s_sync), .oVGA_CLOCK(s_clk));

  vga_timing_gen #(.H_SYNC(2), .H_BACK(2), .H_ACT(4), .H_FRONT(2), .V_SYNC(1), .V_BACK(1),
                   .V_ACT(3), .V_FRONT(1), .HS_POL(1'b1), .VS_POL(1'b0), .COLOR_W(8), .PIX_LAT(0)) u_p0 (
    .iCLK(clk), .iRST(rst),
`ifdef VGA_TESTPATTERN_EN
    .iTP_En(tp_off),
`endif
    .iRed(ff8), .iGreen(ff8), .iBlue(ff8), .oReq(p0_req), .oCoord_X(p0_x), .oCoord_Y(p0_y),
    .oFrame_Start(p0_fs), .oLine_Start(p0_ls), .oVGA_R(p0_r), .oVGA_G(p0_g), .oVGA_B(p0_b),
    .oVGA_H_SYNC(p0_hs), .oVGA_V_SYNC(p0_vs), .oVGA_BLANK(p0_bl), .oVGA_SYNC(p0_sync), .oVGA_CLOCK(p0_clk));

  vga_timing_gen #(.H_SYNC(2), .H_BACK(2), .H_ACT(4), .H_FRONT(2), .V_SYNC(1), .V_BACK(1),
                   .V_ACT(3), .V_FRONT(1), .HS_POL(1'b1), .VS_POL(1'b0), .COLOR_W(8), .PIX_LAT(3)) u_p3 (
    .iCLK(clk), .iRST(rst),
`ifdef VGA_TESTPATTERN_EN
    .iTP_En(tp_off),
`endif
    .iRed(ff8), .iGreen(ff8), .iBlue(ff8), .oReq(p3_req), .oCoord_X(p3_x), .oCoord_Y(p3_y),
    .oFrame_Start(p3_fs), .oLine_Start(p3_ls), .oVGA_R(p3_r), .oVGA_G(p3_g), .oVGA_B(p3_b),
    .oVGA_H_SYNC(p3_hs), .oVGA_V_SYNC(p3_vs), .oVGA_BLANK(p3_bl), .oVGA_SYNC(p3_sync), .oVGA_CLOCK(p3_clk));

  vga_timing_gen u_d (
    .iCLK(clk), .iRST(rst),
`ifdef VGA_TESTPATTERN_EN
    .iTP_En(tp_on),
`endif
    .iRed(d_in), .iGreen(d_in), .iBlue(d_in), .oReq(d_req), .oCoord_X(d_x), .oCoord_Y(d_y),
    .oFrame_Start(d_fs), .oLine_Start(d_ls), .oVGA_R(d_r), .oVGA_G(d_g), .oVGA_B(d_b),
    .oVGA_H_SYNC(d_hs), .oVGA_V_SYNC(d_vs), .oVGA_BLANK(d_bl), .oVGA_SYNC(d_sync), .oVGA_CLOCK(d_clk));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Host for u_s answers one clock after oReq with R = X + 16*Y, all-ones otherwise
  task automatic tick();
    @(posedge clk);
    #1 s_red = s_pend;
    @(negedge clk);
    cyc++;
    s_pend = s_req ? 8'(s_x + 16 * s_y) : 8'hFF;
  endtask

  initial begin
    int s_reqs, s_lsn, s_hsn, s_vsn, s_bln, s_fsn, s_fs_idx;
    int s_first_req, s_first_bl, s_first_hs, p0_first_hs, p0_first_bl, p3_first_hs, p3_first_bl;
    int c_ref, c0, n, n_req;
    logic [7:0] exp_r;
    logic [9:0] exp_hi;
    n_assert = 0; n_fail = 0; cyc = 0;
    s_reqs = 0; s_lsn = 0; s_hsn = 0; s_vsn = 0; s_bln = 0; s_fsn = 0; s_fs_idx = -1;
    s_first_req = -1; s_first_bl = -1; s_first_hs = -1;
    p0_first_hs = -1; p0_first_bl = -1; p3_first_hs = -1; p3_first_bl = -1;
    rst = 1'b1; rst_pulse = 1'b0; s_red = 8'hFF; s_pend = 8'hFF;
    repeat (4) tick();

    chk("rst_s_req", s_req, 0);   chk("rst_s_fs", s_fs, 0);     chk("rst_s_ls", s_ls, 0);
    chk("rst_s_x", s_x, 0);       chk("rst_s_y", s_y, 0);       chk("rst_s_blank", s_bl, 0);
    chk("rst_s_r", s_r, 0);       chk("rst_s_g", s_g, 0);       chk("rst_s_b", s_b, 0);
    chk("rst_s_hs", s_hs, 0);     chk("rst_s_vs", s_vs, 1);     chk("rst_s_sync", s_sync, 0);
    chk("s_clock_fwd", s_clk, 0); chk("rst_d_hs", d_hs, 1);     chk("rst_d_vs", d_vs, 1);
    chk("rst_d_blank", d_bl, 0);

    rst = 1'b0;
    tick();
    c_ref = cyc;
    chk("s_fs_first", s_fs, 1); chk("p0_fs_first", p0_fs, 1);
    chk("p3_fs_first", p3_fs, 1); chk("d_fs_first", d_fs, 1);

    for (int i = 0; i <= 60; i++) begin
      if (i > 0) tick();
      if (i > 0 && s_fs) begin s_fsn++; s_fs_idx = i; end
      if (s_ls) s_lsn++;
      if (s_req) begin
        s_reqs++;
        if (s_first_req < 0) begin
          s_first_req = i;
          chk("s_first_coord_x", s_x, 0); chk("s_first_coord_y", s_y, 0); chk("s_first_ls", s_ls, 1);
        end
        exp_q.push_back(8'(s_x + 16 * s_y));
      end
      if (i == 47) begin
        chk("s_last_req", s_req, 1); chk("s_last_x", s_x, 3); chk("s_last_y", s_y, 2);
      end
      if (s_hs) begin s_hsn++; if (s_first_hs < 0) s_first_hs = i; end
      if (!s_vs) s_vsn++;
      if (p0_hs && p0_first_hs < 0) p0_first_hs = i;
      if (p3_hs && p3_first_hs < 0) p3_first_hs = i;
      if (p0_bl && p0_first_bl < 0) p0_first_bl = i;
      if (p3_bl && p3_first_bl < 0) p3_first_bl = i;
      if (s_bl) begin
        s_bln++;
        if (s_first_bl < 0) s_first_bl = i;
        if (exp_q.size() > 0) exp_r = exp_q.pop_front();
        else exp_r = 8'hEE;
        chk("s_pixel_r", s_r, exp_r); chk("s_pixel_g", s_g, 8'hFF); chk("s_pixel_b", s_b, 8'hFF);
      end else begin
        chk("s_porch_r", s_r, 0); chk("s_porch_g", s_g, 0); chk("s_porch_b", s_b, 0);
      end
    end

    chk("s_req_per_frame", s_reqs, 12);  chk("s_ls_per_frame", s_lsn, 3);
    chk("s_fs_count", s_fsn, 1);         chk("s_fs_period", s_fs_idx, 60);
    chk("s_hs_high_clks", s_hsn, 12);    chk("s_vs_low_clks", s_vsn, 10);
    chk("s_blank_clks", s_bln, 12);      chk("s_first_req_idx", s_first_req, 24);
    chk("s_first_blank_idx", s_first_bl, 26); chk("s_first_hs_idx", s_first_hs, 2);
    chk("p0_first_hs_idx", p0_first_hs, 1);   chk("p0_first_blank_idx", p0_first_bl, 25);
    chk("p3_first_hs_idx", p3_first_hs, 4);   chk("p3_first_blank_idx", p3_first_bl, 28);
    chk("p0_hs_to_blank", p0_first_bl - p0_first_hs, 24);
    chk("p3_hs_to_blank", p3_first_bl - p3_first_hs, 24);

    // Counter now sits at H=1,V=0; advance to H=5,V=3 (stage 1 then shows pixel X=0,Y=1)
    repeat (34) tick();
    chk("pre_rst_req", s_req, 1); chk("pre_rst_x", s_x, 0); chk("pre_rst_y", s_y, 1);
    rst_pulse = 1'b1;
    tick();
    rst_pulse = 1'b0;
    chk("mid_rst_req", s_req, 0); chk("mid_rst_fs", s_fs, 0); chk("mid_rst_ls", s_ls, 0);
    chk("mid_rst_x", s_x, 0);     chk("mid_rst_y", s_y, 0);   chk("mid_rst_blank", s_bl, 0);
    chk("mid_rst_r", s_r, 0);     chk("mid_rst_hs", s_hs, 0); chk("mid_rst_vs", s_vs, 1);
    tick();
    chk("post_rst_fs", s_fs, 1);
    repeat (24) tick();
    chk("post_rst_req", s_req, 1); chk("post_rst_x", s_x, 0);
    chk("post_rst_y", s_y, 0);     chk("post_rst_ls", s_ls, 1);

    n = 0;
    while (!d_req && n < 30000) begin tick(); n++; end
    chk("d_first_req_clk", cyc - c_ref, 28144);
    chk("d_first_x", d_x, 0); chk("d_first_y", d_y, 0); chk("d_first_ls", d_ls, 1);
    c0 = cyc; n_req = 1; n = 0;
    while (!(d_req && d_x == 11'd639) && n < 1000) begin
      tick(); n++;
      if (d_req) n_req++;
    end
    chk("d_last_x_clk", cyc - c0, 639); chk("d_last_x_y", d_y, 0); chk("d_req_per_line", n_req, 640);
    n = 0;
    while (!d_ls && n < 1000) begin tick(); n++; end
    chk("d_line_period", cyc - c0, 800); chk("d_line1_x", d_x, 0); chk("d_line1_y", d_y, 1);

`ifdef VGA_TESTPATTERN_EN
    exp_hi = 10'h3FF;
`else
    exp_hi = 10'h000;
`endif
    repeat (2) tick();
    chk("d_x0_blank", d_bl, 1); chk("d_x0_r", d_r, exp_hi);
    chk("d_x0_g", d_g, exp_hi); chk("d_x0_b", d_b, exp_hi);
    n = 0;
    while (!(d_req && d_x == 11'd100) && n < 200) begin tick(); n++; end
    chk("d_x100_y", d_y, 1);
    repeat (2) tick();
    chk("d_x100_blank", d_bl, 1); chk("d_x100_r", d_r, 0);
    chk("d_x100_g", d_g, 0);      chk("d_x100_b", d_b, exp_hi);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
